// File: rtl/seven_segment_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered BCD image, one shared
// decoder, blanking gap between digits, optional leading-zero blanking.

module bcd7segment (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_c
);
  // Segment order a..g maps to bits 6..0; codes above 9 leave all segments dark
  always_comb begin
    seg_c = 7'h00;
    case (bcd_i)
      4'd0: seg_c = 7'b1111110;
      4'd1: seg_c = 7'b0110000;
      4'd2: seg_c = 7'b1101101;
      4'd3: seg_c = 7'b1111001;
      4'd4: seg_c = 7'b0110011;
      4'd5: seg_c = 7'b1011011;
      4'd6: seg_c = 7'b1011111;
      4'd7: seg_c = 7'b1110000;
      4'd8: seg_c = 7'b1111111;
      4'd9: seg_c = 7'b1111011;
      default: seg_c = 7'h00;
    endcase
  end
endmodule

module seven_segment_scan_ctrl #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned BLANK    = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   DATA_IN,
  input  logic [DIGITS-1:0]     DP_IN,
  input  logic                  LZB_EN,
  output logic [DIGITS-1:0]     DIGIT_SEL,
  output logic [7:0]            SEGMENT,
  output logic                  PENDING,
  output logic                  FRAME_DONE
);

  localparam int unsigned MAX_CNT = (PRESCALE > BLANK) ? PRESCALE : BLANK;
  localparam int unsigned CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;
  localparam int unsigned IDX_W   = $clog2(DIGITS);
  localparam int unsigned IMG_W   = 4 * DIGITS;

  typedef enum logic {ST_BLANK, ST_SHOW} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IMG_W-1:0]    shadow_q, shadow_d, active_q, active_d;
  logic [DIGITS-1:0]   dp_sh_q, dp_sh_d, dp_act_q, dp_act_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic [7:0]          segment_q, segment_d;
  logic                frame_done_q, frame_done_d;

  logic                commit_c;
  logic                zero_run_c;
  logic [DIGITS-1:0]   blank_mask_c;
  logic [3:0]          nibble_c;
  logic [3:0]          bcd_c;
  logic [6:0]          seg7_c;

  // Digit i is dark when it and every more-significant active nibble are zero
  always_comb begin
    zero_run_c   = 1'b1;
    blank_mask_c = '0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run_c      = zero_run_c & (active_q[4*i +: 4] == 4'd0);
      blank_mask_c[i] = LZB_EN & zero_run_c;
    end
  end

  // Outputs are registered, so decode the digit the next state will show
  assign nibble_c = 4'(active_q >> {idx_d, 2'b00});
  assign bcd_c    = blank_mask_c[idx_d] ? 4'hF : nibble_c;

  bcd7segment u_dec (
    .bcd_i (bcd_c),
    .seg_c (seg7_c)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    commit_c     = 1'b0;
    shadow_d     = shadow_q;
    dp_sh_d      = dp_sh_q;
    active_d     = active_q;
    dp_act_d     = dp_act_q;
    pending_d    = pending_q;
    digit_sel_d  = '0;
    segment_d    = 8'h00;
    frame_done_d = 1'b0;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == CNT_W'(BLANK - 1)) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHOW: begin
        if (cnt_q == CNT_W'(PRESCALE - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (idx_q == IDX_W'(DIGITS - 1)) begin
            idx_d    = '0;
            commit_c = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    // Commit takes the pre-edge shadow; a LOAD on the same edge re-arms PENDING
    if (commit_c && pending_q) begin
      active_d  = shadow_q;
      dp_act_d  = dp_sh_q;
      pending_d = 1'b0;
    end
    if (LOAD) begin
      shadow_d  = DATA_IN;
      dp_sh_d   = DP_IN;
      pending_d = 1'b1;
    end

    if (state_d == ST_SHOW) begin
      digit_sel_d = DIGITS'(1) << idx_d;
      segment_d   = {dp_act_q[idx_d], seg7_c};
    end
    frame_done_d = commit_c;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= ST_BLANK;
      cnt_q        <= '0;
      idx_q        <= '0;
      shadow_q     <= '0;
      dp_sh_q      <= '0;
      active_q     <= '0;
      dp_act_q     <= '0;
      pending_q    <= 1'b0;
      digit_sel_q  <= '0;
      segment_q    <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      dp_sh_q      <= dp_sh_d;
      active_q     <= active_d;
      dp_act_q     <= dp_act_d;
      pending_q    <= pending_d;
      digit_sel_q  <= digit_sel_d;
      segment_q    <= segment_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign DIGIT_SEL  = digit_sel_q;
  assign SEGMENT    = segment_q;
  assign PENDING    = pending_q;
  assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Bench for seven_segment_scan_ctrl: a time-slot reference model pushes the
// expected outputs for every clock into a queue; each scenario pops and compares.

module tb_seven_segment_scan_ctrl;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
  localparam int BLANK    = 2;
  localparam int SLOT     = PRESCALE + BLANK;
  localparam int FRAME    = DIGITS * SLOT;

  logic                CLK;
  logic                RST_N;
  logic                LOAD;
  logic [4*DIGITS-1:0] DATA_IN;
  logic [DIGITS-1:0]   DP_IN;
  logic                LZB_EN;
  logic [DIGITS-1:0]   DIGIT_SEL;
  logic [7:0]          SEGMENT;
  logic                PENDING;
  logic                FRAME_DONE;

  seven_segment_scan_ctrl #(
    .DIGITS   (DIGITS),
    .PRESCALE (PRESCALE),
    .BLANK    (BLANK)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .LOAD       (LOAD),
    .DATA_IN    (DATA_IN),
    .DP_IN      (DP_IN),
    .LZB_EN     (LZB_EN),
    .DIGIT_SEL  (DIGIT_SEL),
    .SEGMENT    (SEGMENT),
    .PENDING    (PENDING),
    .FRAME_DONE (FRAME_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  // Reference state: t_m counts edges since the last reset edge
  int                  t_m = 0;
  logic [4*DIGITS-1:0] sh_m, act_m;
  logic [DIGITS-1:0]   dps_m, dpa_m;
  logic                pend_m;
  logic [13:0]         sb[$];
  logic [13:0]         obs, exp_v;

  function automatic logic [6:0] dec(input logic [3:0] b);
    case (b)
      4'd0: return 7'h7E;
      4'd1: return 7'h30;
      4'd2: return 7'h6D;
      4'd3: return 7'h79;
      4'd4: return 7'h33;
      4'd5: return 7'h5B;
      4'd6: return 7'h5F;
      4'd7: return 7'h70;
      4'd8: return 7'h7F;
      4'd9: return 7'h7B;
      default: return 7'h00;
    endcase
  endfunction

  // One clock: update the model with the inputs seen at the edge, queue the result
  task automatic tick();
    logic [13:0]       e;
    logic [DIGITS-1:0] sel;
    logic [7:0]        seg;
    logic              fd, blanked;
    int                k, o;
    @(posedge CLK);
    if (!RST_N) begin
      t_m = 0; sh_m = '0; act_m = '0; dps_m = '0; dpa_m = '0; pend_m = 1'b0;
      e = '0;
    end else begin
      t_m++;
      fd = ((t_m % FRAME) == 0);
      if (fd && pend_m) begin
        act_m  = sh_m;
        dpa_m  = dps_m;
        pend_m = 1'b0;
      end
      if (LOAD) begin
        sh_m   = DATA_IN;
        dps_m  = DP_IN;
        pend_m = 1'b1;
      end
      o = t_m % SLOT;
      k = (t_m / SLOT) % DIGITS;
      sel = '0;
      seg = 8'h00;
      if (o >= BLANK) begin
        sel = 4'b0001 << k;
        blanked = 1'b0;
        if (LZB_EN && k > 0) begin
          blanked = 1'b1;
          for (int j = k; j < DIGITS; j++)
            if (act_m[4*j +: 4] != 4'd0) blanked = 1'b0;
        end
        seg = {dpa_m[k], blanked ? 7'h00 : dec(act_m[4*k +: 4])};
      end
      e = {sel, seg, pend_m, fd};
    end
    sb.push_back(e);
    @(negedge CLK);
  endtask

  function automatic bit showing(input int digit);
    return (t_m % SLOT) >= BLANK && ((t_m / SLOT) % DIGITS) == digit;
  endfunction

  task automatic test_reset();
    RST_N = 1'b0;
    tick();
    obs = {DIGIT_SEL, SEGMENT, PENDING, FRAME_DONE}; exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL reset_state t=%0d got=%h exp=%h", t_m, obs, exp_v);
    end
    RST_N = 1'b1;
    for (int c = 0; c < 2 * FRAME; c++) begin
      tick();
      obs = {DIGIT_SEL, SEGMENT, PENDING, FRAME_DONE}; exp_v = sb.pop_front(); vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL reset_release t=%0d got=%h exp=%h", t_m, obs, exp_v);
      end
      if (t_m >= 2 && t_m < 6) begin
        vectors++;
        if (DIGIT_SEL !== 4'b0001 || SEGMENT !== 8'b01111110) begin
          miscompares++;
          $display("FAIL first_digit0 t=%0d got sel=%b seg=%b exp sel=0001 seg=01111110",
                   t_m, DIGIT_SEL, SEGMENT);
        end
      end
    end
  endtask

  task automatic test_double_buffer();
    for (int c = 0; c < 3 * FRAME; c++) begin
      LOAD = (c == 9); DATA_IN = 16'h1234; DP_IN = '0;
      tick();
      LOAD = 1'b0;
      obs = {DIGIT_SEL, SEGMENT, PENDING, FRAME_DONE}; exp_v = sb.pop_front(); vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL double_buffer t=%0d got=%h exp=%h", t_m, obs, exp_v);
      end
      if (t_m >= 72 && t_m < 96 && showing(3)) begin
        vectors++;
        if (SEGMENT !== 8'b00110000) begin
          miscompares++;
          $display("FAIL digit3_after_commit t=%0d got=%b exp=00110000", t_m, SEGMENT);
        end
      end
    end
  endtask

  task automatic test_lzb();
    for (int c = 0; c < 3 * FRAME; c++) begin
      LOAD = (c == 0); DATA_IN = 16'h0070; DP_IN = '0;
      LZB_EN = (c < 47);
      tick();
      LOAD = 1'b0;
      obs = {DIGIT_SEL, SEGMENT, PENDING, FRAME_DONE}; exp_v = sb.pop_front(); vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL lzb t=%0d got=%h exp=%h", t_m, obs, exp_v);
      end
      if (t_m >= 144 && t_m < 168 && showing(3)) begin
        vectors++;
        if (DIGIT_SEL !== 4'b1000 || SEGMENT !== 8'h00) begin
          miscompares++;
          $display("FAIL lzb_digit3_dark t=%0d got sel=%b seg=%b exp sel=1000 seg=0",
                   t_m, DIGIT_SEL, SEGMENT);
        end
      end
      if (t_m >= 168 && t_m < 192 && showing(3)) begin
        vectors++;
        if (SEGMENT !== 8'b01111110) begin
          miscompares++;
          $display("FAIL lzb_off_digit3 t=%0d got=%b exp=01111110", t_m, SEGMENT);
        end
      end
    end
    LZB_EN = 1'b0;
  endtask

  task automatic test_invalid_dp();
    for (int c = 0; c < 2 * FRAME; c++) begin
      LOAD = (c == 0); DATA_IN = 16'h00A0; DP_IN = 4'b0010;
      tick();
      LOAD = 1'b0;
      obs = {DIGIT_SEL, SEGMENT, PENDING, FRAME_DONE}; exp_v = sb.pop_front(); vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL invalid_dp t=%0d got=%h exp=%h", t_m, obs, exp_v);
      end
      if (t_m >= 216 && showing(1)) begin
        vectors++;
        if (DIGIT_SEL !== 4'b0010 || SEGMENT !== 8'b10000000) begin
          miscompares++;
          $display("FAIL code_a_with_dp t=%0d got sel=%b seg=%b exp sel=0010 seg=10000000",
                   t_m, DIGIT_SEL, SEGMENT);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    DP_IN = '0;
    for (int c = 0; c < 3 * FRAME; c++) begin
      LOAD = (c == 3) || (c == 10) || (c == 23);
      DATA_IN = (c == 3) ? 16'h1111 : (c == 10) ? 16'h2222 : 16'h3333;
      tick();
      LOAD = 1'b0;
      obs = {DIGIT_SEL, SEGMENT, PENDING, FRAME_DONE}; exp_v = sb.pop_front(); vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL back_to_back t=%0d got=%h exp=%h", t_m, obs, exp_v);
      end
      if (t_m >= 264 && t_m < 288 && showing(0)) begin
        vectors++;
        if (SEGMENT !== 8'b01101101 || PENDING !== 1'b1) begin
          miscompares++;
          $display("FAIL last_load_wins t=%0d got seg=%b pend=%b exp seg=01101101 pend=1",
                   t_m, SEGMENT, PENDING);
        end
      end
      if (t_m >= 288 && showing(0)) begin
        vectors++;
        if (SEGMENT !== 8'b01111001) begin
          miscompares++;
          $display("FAIL commit_edge_load t=%0d got=%b exp=01111001", t_m, SEGMENT);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 15; c++) begin
      LOAD = (c == 0); DATA_IN = 16'h5678; DP_IN = 4'b1111;
      tick();
      LOAD = 1'b0;
      obs = {DIGIT_SEL, SEGMENT, PENDING, FRAME_DONE}; exp_v = sb.pop_front(); vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL pre_reset t=%0d got=%h exp=%h", t_m, obs, exp_v);
      end
    end
    RST_N = 1'b0;
    tick();
    RST_N = 1'b1;
    obs = {DIGIT_SEL, SEGMENT, PENDING, FRAME_DONE}; exp_v = sb.pop_front(); vectors++;
    if (obs !== exp_v || PENDING !== 1'b0 || DIGIT_SEL !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_reset got=%h exp=%h", obs, exp_v);
    end
    for (int c = 0; c < FRAME + 6; c++) begin
      tick();
      obs = {DIGIT_SEL, SEGMENT, PENDING, FRAME_DONE}; exp_v = sb.pop_front(); vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL post_reset t=%0d got=%h exp=%h", t_m, obs, exp_v);
      end
      if (t_m >= 2 && t_m < 6) begin
        vectors++;
        if (DIGIT_SEL !== 4'b0001 || SEGMENT !== 8'b01111110) begin
          miscompares++;
          $display("FAIL resume_digit0 t=%0d got sel=%b seg=%b exp sel=0001 seg=01111110",
                   t_m, DIGIT_SEL, SEGMENT);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N   = 1'b0;
    LOAD    = 1'b0;
    DATA_IN = '0;
    DP_IN   = '0;
    LZB_EN  = 1'b0;
    @(negedge CLK);
    test_reset();
    test_double_buffer();
    test_lzb();
    test_invalid_dp();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan_ctrl.md
Name: seven_segment_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-select 7-segment display. It holds a double-buffered BCD digit image, sequences one shared BCD7Segment decoder across all digits, and inserts a blanking gap between digits to prevent ghosting. It sits between the core logic that produces BCD values and the board's segment and digit-select pins.

Parameters:
DIGITS, 4, number of display digits (2..8); digit 0 is the least significant digit.
PRESCALE, 1000, clock cycles each digit is lit (SHOW phase), min 1.
BLANK, 8, clock cycles with all digits off between SHOW phases, min 1.

Ports:
CLK  in  1  system clock, rising edge.
RST_N  in  1  reset; one clock domain; synchronous, active-low.
LOAD  in  1  single-cycle strobe; captures DATA_IN and DP_IN into the shadow register.
DATA_IN  in  4*DIGITS  packed BCD; nibble i is digit i.
DP_IN  in  DIGITS  decimal-point mask; bit i belongs to digit i.
LZB_EN  in  1  leading-zero blanking enable (level, sampled every cycle).
DIGIT_SEL  out  DIGITS  active-high digit enable, one-hot or zero; registered.
SEGMENT  out  8  bit7 = DP, bits 6:0 = a..g from BCD7Segment; registered.
PENDING  out  1  shadow holds data not yet shown.
FRAME_DONE  out  1  one-cycle pulse at the end of each full scan.

Behaviour:
- Reset, sampled on the CLK edge while RST_N=0: DIGIT_SEL=0, SEGMENT=0, PENDING=0, FRAME_DONE=0, active and shadow registers cleared, digit index=0, state=BLANK, phase counter=0.
- FSM states:
  - BLANK: DIGIT_SEL=0, SEGMENT=0; lasts exactly BLANK cycles, then goes to SHOW.
  - SHOW: DIGIT_SEL=1<<idx; SEGMENT={dp, seg[6:0]} for digit idx; lasts exactly PRESCALE cycles, then goes to BLANK.
- Index handling: idx advances on each SHOW->BLANK transition and wraps from DIGITS-1 to 0.
- Output timing: outputs are registered and change on the same edge as the state change. Frame period is DIGITS*(PRESCALE+BLANK) cycles.
- Decoding:
  - One BCD7Segment instance; its BCD input is the active nibble at idx, or 4'hF if that digit is blanked.
  - Codes 10..15 decode to segments off; the digit stays selected.
- Leading-zero blanking: digit i (i>0) is blanked when LZB_EN=1 and all active nibbles i..DIGITS-1 are 0. Digit 0 is never blanked.
- Decimal point: bit7 comes from the active DP mask and is driven even on a blanked or invalid digit.
- Double buffering:
  - LOAD=1 writes shadow<=DATA_IN/DP_IN; PENDING=1 from the next cycle.
  - Multiple LOADs before a commit: last one wins.
- Commit: on the SHOW->BLANK edge with idx=DIGITS-1:
  - FRAME_DONE pulses for 1 cycle.
  - If PENDING, active<=shadow and PENDING<=0.
  - The displayed image never changes mid-frame.
- LOAD on the commit edge: the commit uses the pre-edge shadow; the new data is captured into shadow and PENDING stays 1.
- Reset mid-operation: the next edge forces the reset values. Shadow is discarded and the scan restarts at BLANK with idx 0.
- Counter widths: clog2(max(PRESCALE,BLANK)) bits. No wrap beyond terminal count.

Test Plan:
All scenarios use DIGITS=4, PRESCALE=4, BLANK=2.
1. Reset release: DIGIT_SEL=0 and SEGMENT=0 for 2 cycles. Then DIGIT_SEL=4'b0001, SEGMENT=8'b01111110 for 4 cycles. FRAME_DONE pulses every 24 cycles.
2. Mid-frame LOAD of DATA_IN=16'h1234, DP_IN=0:
   - Display stays all-zero until FRAME_DONE; PENDING stays high until then.
   - Next frame shows digit0=8'b00110011, digit1=8'b01111001, digit2=8'b01101101, digit3=8'b00110000.
3. LZB_EN=1 with 16'h0070:
   - Digits 3 and 2 show SEGMENT=0 with DIGIT_SEL still asserted.
   - Digit1=8'b01110000, digit0=8'b01111110.
   - With LZB_EN=0, digits 3 and 2 show 8'b01111110.
4. Nibble 4'hA at digit1 with DP_IN=4'b0010: digit1 shows SEGMENT=8'b10000000.
5. Two LOADs (16'h1111 then 16'h2222) in one frame, plus a third LOAD (16'h3333) on the commit edge:
   - Next frame shows 2222; PENDING stays 1.
   - The frame after shows 3333.
6. RST_N=0 for 1 cycle mid-SHOW of digit2: next edge DIGIT_SEL=0, SEGMENT=0, PENDING=0. The scan resumes at digit0 showing 0.
